// File: rtl/sorted_vector_serializer.sv
// Single-entry buffer that captures one ascending-sorted packed vector and streams it out smallest-first.
// Optional macro SORTED_VECTOR_SERIALIZER_ORDER_CHECK_EN adds a sticky order_err output flagging unsorted captures.
module sorted_vector_serializer #(
    parameter  int WIDTH = 3,
    parameter  int N     = 8,
    localparam int IW    = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [IW-1:0]      out_index,
    output logic               out_last,
    output logic               busy
`ifdef SORTED_VECTOR_SERIALIZER_ORDER_CHECK_EN
    ,
    output logic               order_err
`endif
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] buf_q [N];
    logic [WIDTH-1:0] in_elem [N];
    logic             beat_xfer;
    logic             is_last;
    logic             capture;

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign in_elem[gi] = in_data[gi*WIDTH +: WIDTH];
    end

    assign is_last   = (idx_q == IW'(N - 1));
    assign beat_xfer = (state_q == SEND) && out_ready;
    // Accepting on the last beat lets consecutive vectors stream with no bubble.
    assign in_ready  = !rst && ((state_q == IDLE) || (beat_xfer && is_last));
    assign capture   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                if (beat_xfer) begin
                    if (is_last) begin
                        idx_d   = '0;
                        state_d = capture ? SEND : IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (capture) begin
                buf_q <= in_elem;
            end
        end
    end

    assign out_valid = (state_q == SEND);
    assign busy      = (state_q == SEND);
    assign out_data  = buf_q[idx_q];
    assign out_index = idx_q;
    assign out_last  = (state_q == SEND) && is_last;

`ifdef SORTED_VECTOR_SERIALIZER_ORDER_CHECK_EN
    logic [N-2:0] unsorted;
    logic         order_err_q;

    for (genvar gi = 0; gi < N - 1; gi++) begin : g_order
        assign unsorted[gi] = (in_elem[gi+1] < in_elem[gi]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            order_err_q <= 1'b0;
        end else if (capture && (|unsorted)) begin
            order_err_q <= 1'b1;
        end
    end

    assign order_err = order_err_q;
`endif

endmodule

// File: tb/tb_sorted_vector_serializer.sv
// Directed plus randomized bench for sorted_vector_serializer, checked against a queue-based beat model.
module tb_sorted_vector_serializer;

    localparam int WIDTH = 3;
    localparam int N     = 8;
    localparam int IW    = $clog2(N);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [N*WIDTH-1:0] in_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [WIDTH-1:0]   out_data;
    logic [IW-1:0]      out_index;
    logic               out_last;
    logic               busy;
`ifdef SORTED_VECTOR_SERIALIZER_ORDER_CHECK_EN
    logic               order_err;
`endif

    sorted_vector_serializer #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy)
`ifdef SORTED_VECTOR_SERIALIZER_ORDER_CHECK_EN
        ,
        .order_err (order_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int idx;
    } beat_t;

    beat_t exp_q[$];
    bit    exp_err = 1'b0;
    int    checks = 0;
    int    failures = 0;
    int    valid_run = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*WIDTH-1:0] pack(input int v[N]);
        logic [N*WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*WIDTH +: WIDTH] = WIDTH'(v[k]);
        return r;
    endfunction

    function automatic logic [N*WIDTH-1:0] rand_vec(input bit sorted);
        int v[N];
        for (int k = 0; k < N; k++) v[k] = int'($urandom_range(0, (1 << WIDTH) - 1));
        if (sorted) v.sort();
        return pack(v);
    endfunction

    task automatic check_outputs();
        chk("out_valid", out_valid, exp_q.size() > 0);
        chk("busy", busy, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            chk("out_data", out_data, exp_q[0].data);
            chk("out_index", out_index, exp_q[0].idx);
            chk("out_last", out_last, exp_q[0].idx == N - 1);
        end
`ifdef SORTED_VECTOR_SERIALIZER_ORDER_CHECK_EN
        chk("order_err", order_err, exp_err);
`endif
    endtask

    // Called at posedge+1: check registered outputs, drive inputs, check in_ready, advance model.
    task automatic step(input bit iv, input logic [N*WIDTH-1:0] d, input bit ordy);
        bit exp_rdy;
        check_outputs();
        valid_run = out_valid ? valid_run + 1 : 0;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        exp_rdy = (exp_q.size() == 0) || (ordy && exp_q.size() == 1 && exp_q[0].idx == N - 1);
        chk("in_ready", in_ready, exp_rdy);
        if (exp_q.size() > 0 && ordy) void'(exp_q.pop_front());
        if (iv && exp_rdy) begin
            for (int k = 0; k < N; k++) begin
                beat_t b;
                b.data = int'(d[k*WIDTH +: WIDTH]);
                b.idx  = k;
                exp_q.push_back(b);
                if (k > 0 && d[k*WIDTH +: WIDTH] < d[(k-1)*WIDTH +: WIDTH]) exp_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = rand_vec(1'b1);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            chk("rst_in_ready", in_ready, 1'b0);
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_out_index", out_index, 0);
            chk("rst_out_last", out_last, 1'b0);
        end
        exp_q.delete();
        exp_err  = 1'b0;
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        int v[N];

        // Reset, then idle
        do_reset(2);
        chk("rst_out_data", out_data, 0);
        step(1'b0, '0, 1'b1);

        // Single vector with downstream always ready
        v = '{0, 1, 2, 3, 4, 5, 6, 7};
        step(1'b1, pack(v), 1'b1);
        for (int i = 0; i < N; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);

        // Backpressure at index 4 for 3 cycles
        v = '{1, 1, 2, 3, 5, 5, 6, 7};
        step(1'b1, pack(v), 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);

        // Back-to-back: second vector held valid during the first drain
        v = '{7, 7, 7, 7, 7, 7, 7, 7};
        step(1'b1, rand_vec(1'b1), 1'b1);
        for (int i = 0; i < N; i++) step(1'b1, pack(v), 1'b1);
        for (int i = 0; i < N; i++) step(1'b0, '0, 1'b1);
        chk("b2b_valid_run", valid_run, 2 * N);
        step(1'b0, '0, 1'b1);

        // Reset mid-drain at index 3
        step(1'b1, rand_vec(1'b1), 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        chk("pre_rst_index", out_index, 3);
        do_reset(1);
        step(1'b1, rand_vec(1'b1), 1'b1);
        for (int i = 0; i < N + 1; i++) step(1'b0, '0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), rand_vec(1'b1), ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 2 * N; i++) step(1'b0, '0, 1'b1);

`ifdef SORTED_VECTOR_SERIALIZER_ORDER_CHECK_EN
        // Order check: unsorted capture sets a sticky flag until reset
        do_reset(1);
        v = '{0, 2, 1, 3, 4, 5, 6, 7};
        step(1'b1, pack(v), 1'b1);
        for (int i = 0; i < N; i++) step(1'b0, '0, 1'b1);
        step(1'b1, rand_vec(1'b1), 1'b1);
        for (int i = 0; i < N + 1; i++) step(1'b0, '0, 1'b1);
        do_reset(1);
        v = '{0, 0, 1, 1, 2, 2, 3, 3};
        step(1'b1, pack(v), 1'b1);
        for (int i = 0; i < N + 1; i++) step(1'b0, '0, 1'b1);
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), rand_vec($urandom_range(0, 7) != 0), 1'b1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
